// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front end: PC, sync-read imem, fetch buffer, redirect flush.
// Optional FETCH_PERF_CNT_EN adds saturating handshake/stall counters.
module fetch_unit #(
    parameter int              XLEN       = 32,
    parameter int              IMEM_DEPTH = 1024,
    parameter int              FIFO_DEPTH = 2,
    parameter logic [XLEN-1:0] RESET_PC   = '0
) (
    input  logic            clk,
    input  logic            arst_n,
    input  logic            imem_we_i,
    input  logic [XLEN-1:0] imem_waddr_i,
    input  logic [XLEN-1:0] imem_wdata_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] out_instr_o,
    output logic [XLEN-1:0] out_pc_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetched_o,
    output logic [31:0]     perf_stall_o
`endif
);
    localparam int AW = $clog2(IMEM_DEPTH);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW+1:0] DEPTH_W = (PW+2)'(FIFO_DEPTH);

    logic [XLEN-1:0] mem [IMEM_DEPTH];
    logic [XLEN-1:0] rd_data_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] req_pc_q;
    logic            inflight_q;

    logic [XLEN-1:0] buf_instr [FIFO_DEPTH];
    logic [XLEN-1:0] buf_pc    [FIFO_DEPTH];
    logic [PW-1:0]   rd_ptr_q;
    logic [PW-1:0]   wr_ptr_q;
    logic [PW:0]     count_q;

    logic [PW+1:0]   occupancy;
    logic            pop;
    logic            push;
    logic            issue;
    logic            unused_addr_bits;

    assign unused_addr_bits = ^{imem_waddr_i, redirect_pc_i};

    // Counting the in-flight read as occupied guarantees its return always has a slot.
    assign occupancy = {1'b0, count_q} + {{(PW+1){1'b0}}, inflight_q};
    assign pop       = out_valid_o && out_ready_i && !redirect_i;
    assign push      = inflight_q && !redirect_i;
    assign issue     = !redirect_i && ((occupancy < DEPTH_W) || pop);

    always_ff @(posedge clk) begin
        if (imem_we_i) begin
            mem[imem_waddr_i[AW+1:2]] <= imem_wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            rd_data_q <= mem[pc_q[AW+1:2]];
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            pc_q       <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else if (redirect_i) begin
            pc_q       <= {redirect_pc_i[XLEN-1:2], 2'b00};
            inflight_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                pc_q     <= pc_q + XLEN'(4);
                req_pc_q <= pc_q;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + (PW+1)'(1);
            end else if (pop && !push) begin
                count_q <= count_q - (PW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                buf_instr[i] <= '0;
                buf_pc[i]    <= '0;
            end
        end else if (push) begin
            buf_instr[wr_ptr_q] <= rd_data_q;
            buf_pc[wr_ptr_q]    <= req_pc_q;
        end
    end

    assign out_valid_o = (count_q != '0);
    assign out_instr_o = buf_instr[rd_ptr_q];
    assign out_pc_o    = buf_pc[rd_ptr_q];

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            perf_fetched_o <= '0;
            perf_stall_o   <= '0;
        end else begin
            if (out_valid_o && out_ready_i && (perf_fetched_o != '1)) begin
                perf_fetched_o <= perf_fetched_o + 32'd1;
            end
            if (!out_valid_o && !redirect_i && (perf_stall_o != '1)) begin
                perf_stall_o <= perf_stall_o + 32'd1;
            end
        end
    end
`endif

endmodule
